// File: rtl/fft_addr_gen.sv
// fft_addr_gen: address sequencer for an in-place radix-2 DIT FFT.
//   LOAD mode emits natural index k with its bit-reversed partner.
//   BFLY mode emits butterfly operand pairs, twiddle index and stage.
// Optional feature macro: FFT_ADDR_GEN_TWIDDLE_EN builds the twiddle index
// logic; when undefined tw_idx is tied to zero.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start; all outputs zero
// LOAD   | bit-reversed load sequence, k = 0..N-1
// BFLY   | butterfly schedule, stage s = 0..LOG2N-1, j = 0..N/2-1
// DONE   | single-cycle completion pulse, then back to IDLE
module fft_addr_gen #(
  parameter int LOG2N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             ready,
  output logic             valid,
  output logic [LOG2N-1:0] addr,
  output logic [LOG2N-1:0] re_addr,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [3:0]       stage,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BFLY, S_DONE} state_t;

  localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
  localparam logic [LOG2N-1:0] K_LAST = '1;
  localparam logic [LOG2N-1:0] J_LAST = LOG2N'((1 << (LOG2N - 1)) - 1);
  localparam logic [3:0]       S_LAST = 4'(LOG2N - 1);

  state_t state_q, state_d;
  // cnt holds k in LOAD and j in BFLY; s is the butterfly stage
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [3:0]       s_q, s_d;

  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LOG2N-1:0] addr_q, addr_d;
  logic [LOG2N-1:0] re_q, re_d;
  logic [LOG2N-1:0] a_q, a_d;
  logic [LOG2N-1:0] b_q, b_d;
  logic [LOG2N-2:0] tw_q, tw_d;
  logic [3:0]       stage_q, stage_d;

  logic [LOG2N-1:0] rev_v;
  logic [LOG2N-1:0] h_v, p_v, g_v, base_v;
`ifdef FFT_ADDR_GEN_TWIDDLE_EN
  logic [3:0]       sh_tw;
`endif

  // Next state and index advance; in LOAD/BFLY valid is always high, so
  // ready alone marks an accepted element.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          s_d     = '0;
          state_d = mode ? S_BFLY : S_LOAD;
        end
      end
      S_LOAD: begin
        if (ready) begin
          if (cnt_q == K_LAST) state_d = S_DONE;
          else                 cnt_d   = cnt_q + ONE;
        end
      end
      S_BFLY: begin
        if (ready) begin
          if (cnt_q == J_LAST) begin
            if (s_q == S_LAST) begin
              state_d = S_DONE;
            end else begin
              cnt_d = '0;
              s_d   = s_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state/index
  // so that every output leaves a flop.
  always_comb begin
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    addr_d  = '0;
    re_d    = '0;
    a_d     = '0;
    b_d     = '0;
    tw_d    = '0;
    stage_d = '0;
    rev_v   = '0;
    for (int i = 0; i < LOG2N; i++) rev_v[i] = cnt_d[LOG2N-1-i];
    // h = 2^s, p = j mod h, g = j / h, operand a = 2*h*g + p
    h_v    = ONE << s_d;
    p_v    = cnt_d & (h_v - ONE);
    g_v    = cnt_d >> s_d;
    base_v = (g_v << (s_d + 4'd1)) | p_v;
`ifdef FFT_ADDR_GEN_TWIDDLE_EN
    sh_tw  = S_LAST - s_d;
`endif
    case (state_d)
      S_LOAD: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        addr_d  = cnt_d;
        re_d    = rev_v;
      end
      S_BFLY: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        a_d     = base_v;
        b_d     = base_v | h_v;
        stage_d = s_d;
`ifdef FFT_ADDR_GEN_TWIDDLE_EN
        // p < 2^s <= N/2, so it fits the narrower twiddle index width
        tw_d    = p_v[LOG2N-2:0] << sh_tw;
`else
        tw_d    = '0;
`endif
      end
      S_DONE:  done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  // State, index and output registers; reset wins over start and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      re_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tw_q    <= tw_d;
      stage_q <= stage_d;
    end
  end

  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign addr    = addr_q;
  assign re_addr = re_q;
  assign addr_a  = a_q;
  assign addr_b  = b_q;
  assign tw_idx  = tw_q;
  assign stage   = stage_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen at LOG2N=3.
module tb_fft_addr_gen;
  localparam int L = 3;
  localparam int N = 1 << L;
`ifdef FFT_ADDR_GEN_TWIDDLE_EN
  localparam bit TW_EN = 1'b1;
`else
  localparam bit TW_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, mode, ready;
  logic valid, busy, done;
  logic [L-1:0] addr, re_addr, addr_a, addr_b;
  logic [L-2:0] tw_idx;
  logic [3:0]   stage;

  fft_addr_gen #(.LOG2N(L)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .ready(ready),
    .valid(valid), .addr(addr), .re_addr(re_addr), .addr_a(addr_a),
    .addr_b(addr_b), .tw_idx(tw_idx), .stage(stage), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr; int re; int a; int b; int tw; int st;
  } elem_t;

  elem_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_done = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference model: bit reversal by digit reflection
  function automatic void push_load();
    elem_t e;
    for (int k = 0; k < N; k++) begin
      e = '{addr: k, re: 0, a: 0, b: 0, tw: 0, st: 0};
      for (int i = 0; i < L; i++)
        if (((k >> i) & 1) == 1) e.re += 1 << (L - 1 - i);
      exp_q.push_back(e);
    end
  endfunction

  // Reference model: classic nested DIT loops (span, group base, offset)
  function automatic void push_bfly();
    elem_t e;
    int h;
    for (int s = 0; s < L; s++) begin
      h = 1 << s;
      for (int base = 0; base < N; base += 2 * h)
        for (int p = 0; p < h; p++) begin
          e = '{addr: 0, re: 0, a: base + p, b: base + p + h,
                tw: TW_EN ? p * (N / (2 * h)) : 0, st: s};
          exp_q.push_back(e);
        end
    end
  endfunction

  // Monitor: compares presented element with scoreboard head, pops on accept
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid) begin
        chk("busy_when_valid", busy, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("addr", addr, exp_q[0].addr);
          chk("re_addr", re_addr, exp_q[0].re);
          chk("addr_a", addr_a, exp_q[0].a);
          chk("addr_b", addr_b, exp_q[0].b);
          chk("tw_idx", tw_idx, exp_q[0].tw);
          chk("stage", stage, exp_q[0].st);
          if (ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_outputs_zero", int'(addr) + int'(re_addr) + int'(addr_a)
            + int'(addr_b) + int'(tw_idx) + int'(stage), 0);
        if (done) begin
          done_cnt++;
          chk("done_busy", busy, 0);
          chk("done_queue_left", exp_q.size(), 0);
        end
      end
    end
  end

  task automatic run_seq(input bit m, input int stall_idx, input int stall_len,
                         input int poke_idx, input int abort_idx, input bit rnd);
    int total, e, stalled, guard;
    bit poked;
    total = m ? (N / 2) * L : N;
    if (m) push_bfly(); else push_load();
    @(posedge clk); #1;
    start = 1'b1; mode = m; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0; stalled = 0; poked = 1'b0; guard = 0;
    while (e < total) begin
      mode  = 1'($urandom % 2);
      start = 1'b0;
      if (e == abort_idx) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        chk("abort_done_later", done, 0);
        chk("abort_valid_later", valid, 0);
        ready = 1'b1;
        return;
      end
      if (e == stall_idx && stalled < stall_len) begin
        ready = 1'b0; stalled++;
      end else if (rnd) begin
        ready = ($urandom % 4) != 0;
      end else begin
        ready = 1'b1;
      end
      if (e == poke_idx && !poked) begin
        start = 1'b1; poked = 1'b1;
      end
      @(posedge clk); #1;
      if (ready) e++;
      guard++;
      if (guard > 5000) begin
        chk("seq_timeout", guard, 0);
        break;
      end
    end
    exp_done++;
    chk("done_pulse", done, 1);
    chk("done_valid", valid, 0);
    start = 1'b1; mode = 1'($urandom % 2);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_width", done, 0);
    chk("start_in_done_ignored", valid, 0);
    @(posedge clk); #1;
    chk("idle_after_done", valid, 0);
    ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addrs", int'(addr) + int'(re_addr) + int'(addr_a) + int'(addr_b), 0);
    chk("rst_tw_stage", int'(tw_idx) + int'(stage), 0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("rst_priority_over_start", valid, 0);
    rst = 1'b0; start = 1'b0;
    mon_en = 1'b1;

    run_seq(1'b0, -1, 0, -1, -1, 1'b0);   // LOAD, ready high
    run_seq(1'b1, -1, 0, -1, -1, 1'b0);   // BFLY, ready high
    run_seq(1'b0, 3, 3, -1, -1, 1'b0);    // LOAD, 3-cycle stall at k=3
    run_seq(1'b1, -1, 0, 6, -1, 1'b0);    // BFLY, start pulse at s=1 j=2
    run_seq(1'b0, -1, 0, -1, 5, 1'b0);    // LOAD, reset at k=5
    run_seq(1'b1, -1, 0, -1, 7, 1'b1);    // BFLY, reset mid-run
    for (int r = 0; r < 10; r++)
      run_seq(1'($urandom % 2), int'($urandom % 8), int'($urandom % 4), -1, -1, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("done_count", done_cnt, exp_done);
    chk("queue_empty_end", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
